// File: rtl/otter_intr_ctrl_if.sv
// IOBUS slice seen by the interrupt controller: MCU address/data/strobe in,
// read data back to the IOBUS_IN mux.
interface otter_intr_ctrl_if;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] RD_DATA;

  modport master (output IOBUS_ADDR, output IOBUS_OUT, output IOBUS_WR, input RD_DATA);
  modport slave  (input IOBUS_ADDR, input IOBUS_OUT, input IOBUS_WR, output RD_DATA);
endinterface

// File: rtl/otter_intr_ctrl.sv
// Interrupt controller for OTTER_MCU: synchronised edge capture, enable masking,
// fixed low-index priority and a claim/EOI handshake driving a registered INTR.
module otter_intr_ctrl #(
  parameter int unsigned NUM_SRC   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h1100_0200
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_SRC-1:0] IRQ_SRC,
  otter_intr_ctrl_if.slave   iobus,
  output logic               INTR
);

  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;

  state_t             state;
  logic               gen;
  logic [NUM_SRC-1:0] enable, pending;
  logic [NUM_SRC-1:0] sync1, sync2, prev;
  logic [4:0]         claim_id;
  logic               valid;

  logic               hit;
  logic [4:0]         off;
  logic               wr_ctrl, wr_enable, wr_pending, wr_claim, wr_eoi;
  logic [NUM_SRC-1:0] edge_set, masked, claim_mask, clear_mask;
  logic               id_live, do_claim;
  logic               cand_valid;
  logic [4:0]         cand_id;

  assign hit        = (iobus.IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
  assign off        = iobus.IOBUS_ADDR[4:0];
  assign wr_ctrl    = iobus.IOBUS_WR && hit && (off == 5'h00);
  assign wr_enable  = iobus.IOBUS_WR && hit && (off == 5'h04);
  assign wr_pending = iobus.IOBUS_WR && hit && (off == 5'h08);
  assign wr_claim   = iobus.IOBUS_WR && hit && (off == 5'h0C);
  assign wr_eoi     = iobus.IOBUS_WR && hit && (off == 5'h10);

  assign edge_set   = sync2 & ~prev;
  assign masked     = pending & enable & {NUM_SRC{gen}};
  // One-hot of the latched id avoids indexing by a 5-bit id when NUM_SRC < 32.
  assign claim_mask = NUM_SRC'(1) << claim_id;
  assign id_live    = |(masked & claim_mask);
  assign do_claim   = (state == ASSERT) && id_live && wr_claim;

  always_comb begin
    clear_mask = '0;
    if (wr_pending) clear_mask = iobus.IOBUS_OUT[NUM_SRC-1:0];
    if (do_claim)   clear_mask = clear_mask | claim_mask;
  end

  always_comb begin
    cand_valid = 1'b0;
    cand_id    = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (masked[i] && !cand_valid) begin
        cand_valid = 1'b1;
        cand_id    = 5'(i);
      end
    end
  end

  always_comb begin
    iobus.RD_DATA = '0;
    if (hit) begin
      case (off)
        5'h00:   iobus.RD_DATA = {31'b0, gen};
        5'h04:   iobus.RD_DATA = 32'(enable);
        5'h08:   iobus.RD_DATA = 32'(pending);
        5'h0C:   iobus.RD_DATA = {valid, 26'b0, claim_id};
        default: iobus.RD_DATA = '0;
      endcase
    end
  end

  // Edge-set is OR-ed in after clearing, so a new edge beats W1C and claim.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1   <= '0;
      sync2   <= '0;
      prev    <= '0;
      gen     <= 1'b0;
      enable  <= '0;
      pending <= '0;
    end else begin
      sync1   <= IRQ_SRC;
      sync2   <= sync1;
      prev    <= sync2;
      if (wr_ctrl)   gen    <= iobus.IOBUS_OUT[0];
      if (wr_enable) enable <= iobus.IOBUS_OUT[NUM_SRC-1:0];
      pending <= (pending & ~clear_mask) | edge_set;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      claim_id <= '0;
      valid    <= 1'b0;
      INTR     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cand_valid) begin
            claim_id <= cand_id;
            valid    <= 1'b1;
            INTR     <= 1'b1;
            state    <= ASSERT;
          end
        end
        ASSERT: begin
          if (!id_live) begin
            INTR  <= 1'b0;
            valid <= 1'b0;
            state <= IDLE;
          end else if (wr_claim) begin
            INTR  <= 1'b0;
            state <= SERVICE;
          end
        end
        SERVICE: begin
          if (wr_eoi) begin
            valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Directed bench for otter_intr_ctrl: stimulus pushes expected read data/INTR
// into a queue, a negedge monitor pops and compares.
module tb_otter_intr_ctrl;

  localparam logic [31:0] BASE = 32'h1100_0200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] irq = '0;
  logic       intr;
  logic       sample = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        intr;
  } exp_t;

  exp_t q[$];

  otter_intr_ctrl_if bus();

  otter_intr_ctrl #(.NUM_SRC(8), .BASE_ADDR(BASE)) dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .IRQ_SRC (irq),
    .iobus   (bus),
    .INTR    (intr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e;
    if (sample) begin
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_underflow: DUT sampled with no expected entry");
      end else begin
        e = q.pop_front();
        vectors++;
        if (bus.RD_DATA !== e.data || intr !== e.intr)
        begin
          miscompares++;
          $display("FAIL %s: got rd_data=%h intr=%b, expected rd_data=%h intr=%b",
                   e.name, bus.RD_DATA, intr, e.data, e.intr);
        end
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w);
    bus.IOBUS_ADDR = a;
    bus.IOBUS_OUT  = d;
    bus.IOBUS_WR   = w;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive('0, '0, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    drive(BASE + off, d, 1'b1);
    @(posedge clk); #1;
    bus.IOBUS_WR = 1'b0;
  endtask

  task automatic rd(input string name, input logic [31:0] off,
                    input logic [31:0] exp_data, input logic exp_intr);
    exp_t e;
    e.name = name;
    e.data = exp_data;
    e.intr = exp_intr;
    drive(BASE + off, '0, 1'b0);
    q.push_back(e);
    sample = 1'b1;
    @(posedge clk); #1;
    sample = 1'b0;
  endtask

  // Pulse sources for one cycle, then idle until the captured edge has
  // propagated through sync1/sync2/prev and the FSM has had an edge to react.
  task automatic pulse(input logic [7:0] src, input int settle);
    irq = src;
    idle(1);
    irq = '0;
    idle(settle);
  endtask

  initial begin
    drive('0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    rd("rst_ctrl",    32'h00, 32'h0, 1'b0);
    rd("rst_enable",  32'h04, 32'h0, 1'b0);
    rd("rst_pending", 32'h08, 32'h0, 1'b0);
    rd("rst_claim",   32'h0C, 32'h0, 1'b0);

    // Basic path: source 2, three-edge latency
    wr(32'h00, 32'h1);
    wr(32'h04, 32'h05);
    pulse(8'h04, 2);
    rd("pend_k2",     32'h08, 32'h04, 1'b0);
    rd("intr_k3",     32'h0C, 32'h8000_0002, 1'b1);
    wr(32'h0C, 32'h0);
    rd("claim_pend",  32'h08, 32'h0, 1'b0);
    rd("claim_reg",   32'h0C, 32'h8000_0002, 1'b0);
    wr(32'h10, 32'h0);
    rd("eoi_claim",   32'h0C, 32'h0000_0002, 1'b0);

    // Priority: sources 0 and 2 together
    pulse(8'h05, 2);
    rd("pend_both",   32'h08, 32'h05, 1'b0);
    rd("prio_claim",  32'h0C, 32'h8000_0000, 1'b1);
    wr(32'h0C, 32'h0);
    rd("after_claim0", 32'h08, 32'h04, 1'b0);
    wr(32'h10, 32'h0);
    rd("eoi_gap",     32'h0C, 32'h0000_0000, 1'b0);
    rd("reassert2",   32'h0C, 32'h8000_0002, 1'b1);
    wr(32'h0C, 32'h0);
    wr(32'h10, 32'h0);
    idle(1);

    // Masked source 1, then enable it
    pulse(8'h02, 3);
    rd("masked",      32'h08, 32'h02, 1'b0);
    wr(32'h04, 32'h02);
    rd("en_edge",     32'h04, 32'h02, 1'b0);
    rd("en_intr",     32'h0C, 32'h8000_0001, 1'b1);
    wr(32'h0C, 32'h0);
    wr(32'h10, 32'h0);
    idle(1);

    // Spurious drop: W1C the asserted id 3
    wr(32'h04, 32'h08);
    pulse(8'h08, 3);
    rd("assert3",     32'h0C, 32'h8000_0003, 1'b1);
    wr(32'h08, 32'h08);
    idle(1);
    rd("spur_drop",   32'h0C, 32'h0000_0003, 1'b0);
    wr(32'h0C, 32'h0);
    wr(32'h10, 32'h0);
    rd("stray_claim", 32'h0C, 32'h0000_0003, 1'b0);
    rd("stray_pend",  32'h08, 32'h0, 1'b0);

    // Pending accumulates during SERVICE
    wr(32'h04, 32'h11);
    pulse(8'h01, 3);
    rd("svc_a0",      32'h0C, 32'h8000_0000, 1'b1);
    wr(32'h0C, 32'h0);
    pulse(8'h10, 3);
    rd("svc_pend",    32'h08, 32'h10, 1'b0);
    rd("svc_hold",    32'h0C, 32'h8000_0000, 1'b0);
    wr(32'h10, 32'h0);
    idle(1);
    rd("svc_reassert", 32'h0C, 32'h8000_0004, 1'b1);
    wr(32'h0C, 32'h0);

    // W1C of bit 4 in the same cycle as a new edge on source 4
    pulse(8'h10, 1);
    wr(32'h08, 32'h10);
    rd("w1c_vs_set",  32'h08, 32'h10, 1'b0);

    // Claim of id 4 in the same cycle as a new edge on source 4
    wr(32'h10, 32'h0);
    pulse(8'h10, 1);
    wr(32'h0C, 32'h0);
    rd("claim_vs_set",    32'h08, 32'h10, 1'b0);
    rd("claim_vs_set_id", 32'h0C, 32'h8000_0004, 1'b0);
    wr(32'h10, 32'h0);
    idle(1);
    rd("pre_rst",     32'h0C, 32'h8000_0004, 1'b1);

    // Asynchronous reset between clock edges while in ASSERT
    #2 rst_n = 1'b0;
    rd("rst_async",   32'h08, 32'h0, 1'b0);
    rd("rst2_ctrl",   32'h00, 32'h0, 1'b0);
    rd("rst2_enable", 32'h04, 32'h0, 1'b0);
    rd("rst2_claim",  32'h0C, 32'h0, 1'b0);
    rst_n = 1'b1;

    wr(32'h00, 32'h1);
    wr(32'h04, 32'hFF);
    rd("unmapped",    32'h14, 32'h0, 1'b0);
    rd("other_block", 32'h20, 32'h0, 1'b0);
    rd("ctrl_rb",     32'h00, 32'h1, 1'b0);
    idle(1);

    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d expected entries never checked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
